alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 8-bit ALU instance between NREQ requesters using round-robin arbitration.
- Each requester offers an operand pair plus a 3-bit opcode over a valid/ready handshake. The block captures the operands, runs the ALU, registers the result and flags, and returns them tagged with the requester id over a valid/ready response channel.
- Sits between the register-file/control units and the ALU; it is the only block that drives the ALU inputs.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- IDW, 2, width of requester id (must satisfy 2**IDW >= NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  8*NREQ  operand A, requester i at [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing.
- req_op  in  3*NREQ  opcode, requester i at [3i+2:3i]. Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl A, 111 shr A.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that issued the op.
- rsp_data  out  8  ALU result.
- rsp_flags  out  4  {Z,N,C,V} from the ALU.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0):
  - State IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0x00; rsp_flags=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Reset mid-operation aborts the op with no response.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from last+1 upward with wrap modulo NREQ.
  - req_ready = onehot(grant), combinational, only in IDLE; all zero in other states.
  - On accept (req_valid[i] & req_ready[i]): capture a, b, op, id into internal registers; last<=i; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC: drive the ALU from the captured registers. At the clock edge, register the ALU out and flags into rsp_data/rsp_flags, set rsp_id=captured id, set rsp_valid<=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_data and rsp_flags stable while rsp_ready=0.
  - When rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE. rsp_data/rsp_flags keep their last values.
- Latency and throughput:
  - Accept at edge k; rsp_valid is high after edge k+1.
  - With rsp_ready tied high: one op per 3 cycles; the next accept can occur at edge k+3.
- Requester rules:
  - Requesters must hold valid and payload stable until accepted.
  - Dropping valid before acceptance is legal; that requester is simply not granted.
  - Payload changes after acceptance have no effect on the op in flight.
- Flag semantics (ALU-defined):
  - Z = result==0.
  - N = result[7].
  - C = carry for add, borrow (inverted carry) for sub, shifted-out bit for shl/shr, 0 otherwise.
  - V = signed overflow for add/sub, 0 otherwise.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Only one op is in flight at a time; there is no queueing inside the block.

Test Plan:
- Single add: req0 a=0x7F b=0x01 op=000 -> req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=0x80, flags {Z,N,C,V}=0101.
- Sub borrow: req1 a=0x00 b=0x01 op=001 -> rsp_id=1, rsp_data=0xFF, flags=0110. Also a=0x05 b=0x05 op=001 -> rsp_data=0x00, flags=1000.
- Contention (NREQ=2): both valid continuously from reset, rsp_ready=1 -> grant order 0,1,0,1; the rsp_id sequence matches; each accept is 3 cycles apart.
- Backpressure: after a shl of a=0x81 (rsp_data=0x02, flags=0010), hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready stays 0 despite pending req_valid, busy=1. Release -> return to IDLE next cycle, then a new accept.
- Reset mid-op: assert rst_n=0 while in EXEC -> rsp_valid, req_ready and busy go 0 immediately. After release, req0 wins first even if req1 was last granted.
- Wrap/fairness (NREQ=3): req2 and req0 valid, last=2 -> req0 granted, then req2.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 8-bit ALU between NREQ requesters
module alu_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   input  logic [3*NREQ-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_data,
   output logic [3:0]        rsp_flags,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] last;
   logic [IDW-1:0] grant_idx;
   logic           grant_found;
   logic           accept;
   logic [7:0]     sel_a, sel_b;
   logic [2:0]     sel_op;
   logic [7:0]     cap_a, cap_b;
   logic [2:0]     cap_op;
   logic [IDW-1:0] cap_id;
   logic [8:0]     sum9, diff9;
   logic [7:0]     alu_y;
   logic           alu_c, alu_v;

   // Round-robin search starting just after the last winner; the nearest candidate is written last and wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (i == (int'(last) + k) % NREQ)) begin
               grant_found = 1'b1;
               grant_idx   = IDW'(i);
            end
         end
      end
   end

   // Payload mux for the current grant candidate
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == grant_idx) begin
            sel_a  = req_a[8*i +: 8];
            sel_b  = req_b[8*i +: 8];
            sel_op = req_op[3*i +: 3];
         end
      end
   end

   assign accept = (state == S_IDLE) && grant_found;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: one op in flight, response must be taken before the next grant
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: grants only in IDLE and never while reset is held
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = rst_n && (state == S_IDLE) && grant_found && (IDW'(i) == grant_idx);
      end
      busy = (state != S_IDLE);
   end

   // ALU on the captured operands; C is borrow for sub, the shifted-out bit for shifts
   always_comb begin
      sum9  = {1'b0, cap_a} + {1'b0, cap_b};
      diff9 = {1'b0, cap_a} - {1'b0, cap_b};
      alu_y = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (cap_op)
         3'b000: begin
            alu_y = sum9[7:0];
            alu_c = sum9[8];
            alu_v = (cap_a[7] == cap_b[7]) && (alu_y[7] != cap_a[7]);
         end
         3'b001: begin
            alu_y = diff9[7:0];
            alu_c = diff9[8];
            alu_v = (cap_a[7] != cap_b[7]) && (alu_y[7] != cap_a[7]);
         end
         3'b010: alu_y = cap_a & cap_b;
         3'b011: alu_y = cap_a | cap_b;
         3'b100: alu_y = cap_a ^ cap_b;
         3'b101: alu_y = ~cap_a;
         3'b110: begin
            alu_y = {cap_a[6:0], 1'b0};
            alu_c = cap_a[7];
         end
         default: begin
            alu_y = {1'b0, cap_a[7:1]};
            alu_c = cap_a[0];
         end
      endcase
   end

   // Operand capture, round-robin pointer and registered response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last      <= IDW'(NREQ - 1);
         cap_a     <= '0;
         cap_b     <= '0;
         cap_op    <= '0;
         cap_id    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
      end else begin
         if (accept) begin
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_op <= sel_op;
            cap_id <= grant_idx;
            last   <= grant_idx;
         end
         if (state == S_EXEC) begin
            rsp_data  <= alu_y;
            rsp_flags <= {(alu_y == 8'h00), alu_y[7], alu_c, alu_v};
            rsp_id    <= cap_id;
            rsp_valid <= 1'b1;
         end else if ((state == S_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with three requesters
module tb_alu_arbiter;

   localparam int N   = 3;
   localparam int IDW = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [8*N-1:0]   req_a;
   logic [8*N-1:0]   req_b;
   logic [3*N-1:0]   req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [7:0]       rsp_data;
   logic [3:0]       rsp_flags;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int m_last = N - 1;

   alu_arbiter #(.NREQ(N), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference ALU from the arithmetic definition: returns {result, Z, N, C, V}
   function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
      int r, c, v, sa, sb, s;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      c = 0;
      v = 0;
      case (op)
         0: begin r = (a + b) % 256; c = (a + b > 255); s = sa + sb; v = (s > 127 || s < -128); end
         1: begin r = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 255 - a;
         6: begin r = (a * 2) % 256; c = a / 128; end
         7: begin r = a / 2; c = a % 2; end
         default: r = 0;
      endcase
      return {8'(r), (r == 0), (r > 127), (c != 0), (v != 0)};
   endfunction

   // Round-robin reference: nearest valid requester after the last winner
   function automatic int rr_pick(input int last, input logic [N-1:0] mask);
      for (int k = 1; k <= N; k++) begin
         if (mask[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [11:0] ref_for(input int g);
      return ref_alu(int'(req_a[8*g +: 8]), int'(req_b[8*g +: 8]), int'(req_op[3*g +: 3]));
   endfunction

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
      req_op[3*i +: 3] = op;
   endtask

   // One complete transaction from IDLE: grant, execute, optional backpressure, release
   task automatic run_txn(input logic [N-1:0] mask, input int stall);
      int g;
      logic [11:0] e;
      g = rr_pick(m_last, mask);
      req_valid = mask;
      #1;
      chk("grant", 32'(req_ready), 32'(1) << g);
      chk("idle_busy", 32'(busy), 0);
      e = ref_for(g);
      tick();
      m_last = g;
      req_valid = '0;
      req_a  = 24'($urandom);
      req_b  = 24'($urandom);
      req_op = 9'($urandom);
      chk("exec_busy", 32'(busy), 1);
      chk("exec_ready", 32'(req_ready), 0);
      chk("exec_rsp_valid", 32'(rsp_valid), 0);
      tick();
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_data", 32'(rsp_data), 32'(e[11:4]));
      chk("rsp_flags", 32'(rsp_flags), 32'(e[3:0]));
      req_valid = '1;
      for (int s = 0; s < stall; s++) begin
         tick();
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_id", 32'(rsp_id), 32'(g));
         chk("hold_data", 32'(rsp_data), 32'(e[11:4]));
         chk("hold_flags", 32'(rsp_flags), 32'(e[3:0]));
         chk("hold_ready", 32'(req_ready), 0);
         chk("hold_busy", 32'(busy), 1);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("done_valid", 32'(rsp_valid), 0);
      chk("done_busy", 32'(busy), 0);
      chk("done_data_kept", 32'(rsp_data), 32'(e[11:4]));
   endtask

   initial begin
      int g, prev, ngrant;
      int q_id[$];
      logic [11:0] q_res[$];
      logic [11:0] e;

      rst_n = 1'b0;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      req_op = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("reset_ready", 32'(req_ready), 0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_id", 32'(rsp_id), 0);
      chk("reset_rsp_data", 32'(rsp_data), 0);
      chk("reset_rsp_flags", 32'(rsp_flags), 0);
      chk("reset_busy", 32'(busy), 0);
      req_valid = '0;
      rst_n = 1'b1;
      tick();

      set_req(0, 8'h7F, 8'h01, 3'b000);
      run_txn(3'b001, 0);
      chk("add_data", 32'(rsp_data), 32'h80);
      chk("add_flags", 32'(rsp_flags), 32'b0101);

      set_req(1, 8'h00, 8'h01, 3'b001);
      run_txn(3'b010, 0);
      chk("sub_borrow_data", 32'(rsp_data), 32'hFF);
      chk("sub_borrow_flags", 32'(rsp_flags), 32'b0110);

      set_req(0, 8'h05, 8'h05, 3'b001);
      run_txn(3'b001, 0);
      chk("sub_zero_data", 32'(rsp_data), 32'h00);
      chk("sub_zero_flags", 32'(rsp_flags), 32'b1000);

      set_req(2, 8'h81, 8'h00, 3'b110);
      run_txn(3'b100, 5);
      chk("shl_data", 32'(rsp_data), 32'h02);
      chk("shl_flags", 32'(rsp_flags), 32'b0010);

      run_txn(3'b101, 1);
      chk("wrap_first_id", 32'(rsp_id), 0);
      run_txn(3'b101, 0);
      chk("wrap_second_id", 32'(rsp_id), 2);

      set_req(0, 8'h12, 8'h34, 3'b000);
      req_valid = 3'b001;
      #1;
      chk("midop_grant", 32'(req_ready), 1);
      tick();
      chk("midop_exec_busy", 32'(busy), 1);
      req_valid = 3'b011;
      rst_n = 1'b0;
      #1;
      chk("midop_rst_valid", 32'(rsp_valid), 0);
      chk("midop_rst_ready", 32'(req_ready), 0);
      chk("midop_rst_busy", 32'(busy), 0);
      tick();
      rst_n = 1'b1;
      m_last = N - 1;
      #1;

      req_a  = 24'($urandom);
      req_b  = 24'($urandom);
      req_op = 9'($urandom);
      rsp_ready = 1'b1;
      prev = -1;
      ngrant = 0;
      for (int c = 0; c < 12; c++) begin
         if (req_ready != '0) begin
            g = rr_pick(m_last, 3'b011);
            chk("cont_grant", 32'(req_ready), 32'(1) << g);
            if (prev >= 0) chk("cont_spacing", c - prev, 3);
            prev = c;
            m_last = g;
            ngrant++;
            q_id.push_back(g);
            q_res.push_back(ref_for(g));
         end
         if (rsp_valid) begin
            if (q_id.size() > 0) begin
               e = q_res.pop_front();
               chk("cont_rsp_id", 32'(rsp_id), 32'(q_id.pop_front()));
               chk("cont_rsp_data", 32'(rsp_data), 32'(e[11:4]));
               chk("cont_rsp_flags", 32'(rsp_flags), 32'(e[3:0]));
            end else begin
               chk("cont_rsp_unexpected", 32'(rsp_valid), 0);
            end
         end
         if (c == 11) req_valid = '0;
         tick();
      end
      rsp_ready = 1'b0;
      chk("cont_grants", ngrant, 4);
      chk("cont_pending", q_id.size(), 0);
      chk("cont_idle", 32'(busy), 0);

      for (int t = 0; t < 40; t++) begin
         req_a  = 24'($urandom);
         req_b  = 24'($urandom);
         req_op = 9'($urandom);
         run_txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
